fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the decoder. After reset it loads the program counter from the reset vector, then for each instruction it reads the opcode and its operand bytes from memory and forms the effective base address. It presents the opcode and address to the decoder with an `instruction_ready`/`instruction_done` handshake, and applies any PC redirect requested when the instruction retires.

## Interface
- `REG_WIDTH`, 8: data/opcode width.
- `ADDR_WIDTH`, 16: address and PC width.
- `RESET_VECTOR`, 16'hFFFC: address of the reset vector low byte; the high byte is at +1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_addr`  out  ADDR_WIDTH  memory read address.
- `mem_rd`  out  1  read request.
- `mem_data_in`  in  REG_WIDTH  read data; valid when `mem_valid`=1.
- `mem_valid`  in  1  read data valid; ignored while `mem_rd`=0.
- `instruction`  out  REG_WIDTH  opcode to the decoder.
- `operand`  out  REG_WIDTH  first operand byte (0 if none).
- `addr`  out  ADDR_WIDTH  effective base address for the decoder.
- `instruction_ready`  out  1  opcode, operand and address are valid.
- `instruction_done`  in  1  decoder has finished the current instruction.
- `pc_load`  in  1  redirect the PC on retire.
- `pc_load_value`  in  ADDR_WIDTH  redirect target.
- `pc_out`  out  ADDR_WIDTH  current PC, for debug and stack pushes.

## Operation
- States: VEC_LO, VEC_HI, FETCH_OP, FETCH_LO, FETCH_HI, PRESENT, ISSUE.
- Memory handshake:
  - In any fetch state, `mem_rd`=1 and `mem_addr` holds the target.
  - The state holds until an edge at which `mem_valid`=1; `mem_data_in` is sampled at that edge.
  - Zero-wait memory (`mem_valid` tied to 1) gives one cycle per byte.
- Reset vector fetch:
  - VEC_LO reads `RESET_VECTOR` into PC[7:0].
  - VEC_HI reads `RESET_VECTOR`+1 into PC[15:8], then goes to FETCH_OP.
- FETCH_OP:
  - Reads the byte at PC and latches the opcode; PC <= PC+1.
  - Operand count N comes from opcode bits bbb=[4:2] and cc=[1:0]:
    - bbb 000, 001, 100, 101 -> N=1.
    - bbb 011, 111 -> N=2.
    - bbb 010 -> N=1 if cc=01, else 0.
    - bbb 110 -> N=2 if cc=01, else 0.
  - Next state: N=0 -> PRESENT; otherwise FETCH_LO.
- FETCH_LO:
  - Latches the byte at PC as `lo` and records `opaddr`=PC; PC <= PC+1.
  - Next state: N=2 -> FETCH_HI; otherwise PRESENT.
- FETCH_HI: latches `hi`; PC <= PC+1; goes to PRESENT.
- PRESENT (one cycle, `instruction_ready`=0) registers the outputs:
  - `instruction` <= opcode.
  - `operand` <= `lo` (0 if N=0).
  - `addr` is selected as follows:
    - N=2 -> {hi, lo}.
    - Immediate (bbb=010 with cc=01, or bbb=000 with cc≠01) -> `opaddr`.
    - Other N=1 -> {8'h00, lo} (zero page).
    - N=0 -> PC.
  - Indexing (X/Y) is not applied here.
- ISSUE:
  - `instruction_ready`=1; outputs held stable.
  - `instruction_done` is ignored on the first ISSUE edge, because the decoder's done flag from the previous instruction may still be high.
  - On any later edge with `instruction_done`=1: go to FETCH_OP and drop `instruction_ready`; if `pc_load`=1 on that same edge, PC <= `pc_load_value`.
- `pc_load` outside ISSUE has no effect.
- PC arithmetic is modulo 2^ADDR_WIDTH: 16'hFFFF+1 = 16'h0000.
- `mem_addr` wraps the same way during operand fetch.

## Timing
- Reset values: state=VEC_LO, PC=0, `mem_rd`=0, `mem_addr`=`RESET_VECTOR`, `instruction`=0, `operand`=0, `addr`=0, `instruction_ready`=0, `pc_out`=0.
- `mem_rd` rises on the first edge after `reset` deasserts.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously), `mem_rd` drops without waiting for `mem_valid`, and the block restarts at VEC_LO.
- Zero-wait latency, counted in edges from FETCH_OP entry to `instruction_ready`=1: N=0 -> 3, N=1 -> 4, N=2 -> 5. Each memory wait cycle adds 1.
- `instruction`, `operand` and `addr` become stable one full cycle before `instruction_ready` rises and stay stable until it falls.
- Minimum ISSUE duration is 2 cycles.
- Redirect: the first `mem_addr` after a redirect equals `pc_load_value`.

## Test plan
- Reset vector: memory[FFFC]=00, [FFFD]=80, zero-wait -> `mem_addr` sequence FFFC, FFFD, 8000; `pc_out`=8000.
- Absolute: AD 34 12 at 8000 -> `instruction`=AD, `addr`=1234, `operand`=34, ready on edge 5, `pc_out`=8003.
- Zero page and immediate:
  - A5 44 -> `addr`=0044.
  - A9 7F at 8010 -> `addr`=8011, `operand`=7F.
  - EA (N=0) -> ready on edge 3, `addr`=PC.
- Handshake: `instruction_done` held high into ISSUE -> first edge ignored, advance on the second. `pc_load`=1, `pc_load_value`=C000 with done -> next `mem_addr`=C000.
- Wait states: `mem_valid` low for 3 cycles on each byte of AD 00 20 -> `mem_rd` held, `mem_addr` stable, ready 9 cycles later than the zero-wait case, `addr`=2000.
- Wrap and reset: opcode AD at FFFE -> operands read from FFFF and 0000, PC ends at 0001. Assert `reset` in FETCH_HI -> `mem_rd`=0 and `instruction_ready`=0 immediately, then the vector fetch restarts.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: memory read port on one side, decoder handshake on the other.
// The fetch unit drives the master modport; memory and decoder sit behind slave.
interface fetch_unit_if #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic [REG_WIDTH-1:0]  mem_data_in;
    logic                  mem_valid;
    logic [REG_WIDTH-1:0]  instruction;
    logic [REG_WIDTH-1:0]  operand;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  instruction_ready;
    logic                  instruction_done;
    logic                  pc_load;
    logic [ADDR_WIDTH-1:0] pc_load_value;
    logic [ADDR_WIDTH-1:0] pc_out;

    modport master (
        output mem_addr, mem_rd, instruction, operand, addr, instruction_ready, pc_out,
        input  mem_data_in, mem_valid, instruction_done, pc_load, pc_load_value
    );

    modport slave (
        input  mem_addr, mem_rd, instruction, operand, addr, instruction_ready, pc_out,
        output mem_data_in, mem_valid, instruction_done, pc_load, pc_load_value
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: loads PC from the reset vector, reads opcode plus operand
// bytes, forms the base address and hands it to the decoder via ready/done.
module fetch_unit #(
    parameter int                    REG_WIDTH    = 8,
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hFFFC
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        VEC_LO, VEC_HI, FETCH_OP, FETCH_LO, FETCH_HI, PRESENT, ISSUE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] opaddr;
    logic [REG_WIDTH-1:0]  opcode;
    logic [REG_WIDTH-1:0]  lo;
    logic [REG_WIDTH-1:0]  hi;
    logic [1:0]            nops;
    logic                  take;

    // Operand byte count from the bbb/cc opcode fields.
    function automatic logic [1:0] op_count(input logic [REG_WIDTH-1:0] op);
        case (op[4:2])
            3'b011, 3'b111: return 2'd2;
            3'b010:         return (op[1:0] == 2'b01) ? 2'd1 : 2'd0;
            3'b110:         return (op[1:0] == 2'b01) ? 2'd2 : 2'd0;
            default:        return 2'd1;
        endcase
    endfunction

    function automatic logic is_imm(input logic [REG_WIDTH-1:0] op);
        return (op[4:2] == 3'b010 && op[1:0] == 2'b01) ||
               (op[4:2] == 3'b000 && op[1:0] != 2'b01);
    endfunction

    assign pc_inc     = pc + ADDR_WIDTH'(1);
    assign take       = bus.mem_rd & bus.mem_valid;
    assign bus.pc_out = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                 <= VEC_LO;
            pc                    <= '0;
            opaddr                <= '0;
            opcode                <= '0;
            lo                    <= '0;
            hi                    <= '0;
            nops                  <= '0;
            bus.mem_rd            <= 1'b0;
            bus.mem_addr          <= RESET_VECTOR;
            bus.instruction       <= '0;
            bus.operand           <= '0;
            bus.addr              <= '0;
            bus.instruction_ready <= 1'b0;
        end else begin
            case (state)
                VEC_LO: begin
                    // First cycle out of reset only raises the read request.
                    if (!bus.mem_rd) begin
                        bus.mem_rd <= 1'b1;
                    end else if (take) begin
                        pc[REG_WIDTH-1:0] <= bus.mem_data_in;
                        bus.mem_addr      <= RESET_VECTOR + ADDR_WIDTH'(1);
                        state             <= VEC_HI;
                    end
                end
                VEC_HI: if (take) begin
                    pc[ADDR_WIDTH-1:REG_WIDTH] <= bus.mem_data_in;
                    bus.mem_addr <= ADDR_WIDTH'({bus.mem_data_in, pc[REG_WIDTH-1:0]});
                    state        <= FETCH_OP;
                end
                FETCH_OP: if (take) begin
                    opcode <= bus.mem_data_in;
                    nops   <= op_count(bus.mem_data_in);
                    pc     <= pc_inc;
                    if (op_count(bus.mem_data_in) == 2'd0) begin
                        bus.mem_rd <= 1'b0;
                        state      <= PRESENT;
                    end else begin
                        bus.mem_addr <= pc_inc;
                        state        <= FETCH_LO;
                    end
                end
                FETCH_LO: if (take) begin
                    lo     <= bus.mem_data_in;
                    opaddr <= pc;
                    pc     <= pc_inc;
                    if (nops == 2'd2) begin
                        bus.mem_addr <= pc_inc;
                        state        <= FETCH_HI;
                    end else begin
                        bus.mem_rd <= 1'b0;
                        state      <= PRESENT;
                    end
                end
                FETCH_HI: if (take) begin
                    hi         <= bus.mem_data_in;
                    pc         <= pc_inc;
                    bus.mem_rd <= 1'b0;
                    state      <= PRESENT;
                end
                PRESENT: begin
                    bus.instruction <= opcode;
                    bus.operand     <= (nops == 2'd0) ? '0 : lo;
                    if (nops == 2'd2)      bus.addr <= ADDR_WIDTH'({hi, lo});
                    else if (nops == 2'd0) bus.addr <= pc;
                    else if (is_imm(opcode)) bus.addr <= opaddr;
                    else                   bus.addr <= ADDR_WIDTH'(lo);
                    state <= ISSUE;
                end
                ISSUE: begin
                    // Ready lags ISSUE entry by one edge, so a done left high by
                    // the previous instruction cannot retire this one.
                    if (!bus.instruction_ready) begin
                        bus.instruction_ready <= 1'b1;
                    end else if (bus.instruction_done) begin
                        bus.instruction_ready <= 1'b0;
                        bus.mem_rd            <= 1'b1;
                        state                 <= FETCH_OP;
                        if (bus.pc_load) begin
                            pc           <= bus.pc_load_value;
                            bus.mem_addr <= bus.pc_load_value;
                        end else begin
                            bus.mem_addr <= pc;
                        end
                    end
                end
                default: state <= VEC_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory/decoder responder with a transaction-level
// model of expected reads, outputs and latency, plus directed literal checks.
module tb_fetch_unit;

    localparam logic [15:0] RV = 16'hFFFC;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  opd;
        logic [15:0] addr;
        logic [15:0] pc_end;
        int          n;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    fetch_unit_if #(.REG_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    fetch_unit #(.REG_WIDTH(8), .ADDR_WIDTH(16), .RESET_VECTOR(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [7:0]  mem [0:65535];
    logic [15:0] rdq [$];
    exp_t        ex;
    bit          en = 0, have_exp = 0, vec_phase = 1, seen_ready = 0;
    int          entry = 0, waits = 0, wcnt = 0, n_issued = 0, last_lat = 0;
    int          wmode = 0, done_mode = 0;
    bit          rnd_ld = 0, ld_en = 0;
    logic [15:0] ld_val = 16'h0;
    logic [7:0]  p_instr, p_opd;
    logic [15:0] p_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic fail_note(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: got event, expected none", nm);
    endtask

    // What the decoder must see for an instruction starting at s.
    function automatic exp_t model(input logic [15:0] s);
        exp_t e;
        logic [7:0] op;
        logic [2:0] b;
        logic [1:0] c;
        op = mem[s];
        b  = op[4:2];
        c  = op[1:0];
        e.op = op;
        if (b == 3'd3 || b == 3'd7) e.n = 2;
        else if (b == 3'd2)         e.n = (c == 2'd1) ? 1 : 0;
        else if (b == 3'd6)         e.n = (c == 2'd1) ? 2 : 0;
        else                        e.n = 1;
        e.opd    = (e.n > 0) ? mem[s + 16'd1] : 8'h00;
        e.pc_end = s + 16'(1 + e.n);
        if (e.n == 2)      e.addr = {mem[s + 16'd2], mem[s + 16'd1]};
        else if (e.n == 0) e.addr = e.pc_end;
        else if ((b == 3'd2 && c == 2'd1) || (b == 3'd0 && c != 2'd1)) e.addr = s + 16'd1;
        else               e.addr = {8'h00, mem[s + 16'd1]};
        return e;
    endfunction

    task automatic start_instr(input logic [15:0] s);
        ex = model(s);
        for (int i = 0; i <= ex.n; i++) rdq.push_back(s + 16'(i));
        have_exp   = 1;
        entry      = cyc + 1;
        waits      = 0;
        wcnt       = 0;
        seen_ready = 0;
    endtask

    task automatic reinit();
        rdq.delete();
        rdq.push_back(RV);
        rdq.push_back(RV + 16'd1);
        have_exp = 0; vec_phase = 1; seen_ready = 0; waits = 0; wcnt = 0;
    endtask

    // Memory responder, decoder driver and per-cycle compare against the model.
    initial begin
        bit v, dn, ld, rd, rdy;
        logic [15:0] a, lv;
        bus.mem_valid = 0; bus.mem_data_in = 0; bus.instruction_done = 0;
        bus.pc_load = 0; bus.pc_load_value = 0;
        forever begin
            @(negedge clk);
            if (!en) begin
                bus.mem_valid = 0; bus.instruction_done = 0; bus.pc_load = 0;
            end else begin
                rd  = bus.mem_rd;
                rdy = bus.instruction_ready;
                v   = 1;
                if (rd) begin
                    if (wmode == 1) v = ($urandom_range(0, 3) != 0);
                    else if (wmode == 2) begin
                        if (wcnt < 3) begin v = 0; wcnt++; end
                        else begin v = 1; wcnt = 0; end
                    end
                    if (rdq.size() == 0) fail_note("unexpected_read");
                    else begin
                        chk("mem_addr", 32'(bus.mem_addr), 32'(rdq[0]));
                        if (v) begin
                            a = rdq.pop_front();
                            if (vec_phase && a == RV + 16'd1) begin
                                vec_phase = 0;
                                start_instr({mem[RV + 16'd1], mem[RV]});
                            end
                        end else if (!vec_phase) waits++;
                    end
                    bus.mem_valid   = v;
                    bus.mem_data_in = v ? mem[bus.mem_addr] : 8'($urandom);
                end else begin
                    bus.mem_valid   = 1'($urandom_range(0, 1));
                    bus.mem_data_in = 8'($urandom);
                end
                if (rdy) begin
                    chk("rd_while_ready", 32'(rd), 32'd0);
                    if (!have_exp) fail_note("ready_without_instruction");
                    else begin
                        chk("instruction", 32'(bus.instruction), 32'(ex.op));
                        chk("operand", 32'(bus.operand), 32'(ex.opd));
                        chk("addr", 32'(bus.addr), 32'(ex.addr));
                        chk("pc_out", 32'(bus.pc_out), 32'(ex.pc_end));
                        if (!seen_ready) begin
                            seen_ready = 1;
                            n_issued++;
                            last_lat = cyc - entry;
                            chk("latency", 32'(last_lat), 32'(3 + ex.n + waits));
                            chk("pre_instruction", 32'(p_instr), 32'(ex.op));
                            chk("pre_operand", 32'(p_opd), 32'(ex.opd));
                            chk("pre_addr", 32'(p_addr), 32'(ex.addr));
                        end
                    end
                end
                dn = (done_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.instruction_done = dn;
                if (rdy && dn && have_exp) begin
                    ld = rnd_ld ? ($urandom_range(0, 3) == 0) : ld_en;
                    lv = rnd_ld ? 16'($urandom) : ld_val;
                    bus.pc_load = ld;
                    bus.pc_load_value = lv;
                    start_instr(ld ? lv : ex.pc_end);
                end else begin
                    bus.pc_load       = 1'($urandom_range(0, 1));
                    bus.pc_load_value = 16'($urandom);
                end
                p_instr = bus.instruction;
                p_opd   = bus.operand;
                p_addr  = bus.addr;
            end
        end
    end

    task automatic wait_issue(input int k);
        int t = 0;
        while (n_issued < k && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        chk("issue_reached", 32'(n_issued >= k), 32'd1);
    endtask

    initial begin
        bit found;
        int base, t;
        reset = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
        mem[16'h8003] = 8'hA5; mem[16'h8004] = 8'h44;
        mem[16'h8005] = 8'hEA;
        mem[16'h8010] = 8'hA9; mem[16'h8011] = 8'h7F;
        mem[16'hC000] = 8'hAD; mem[16'hC001] = 8'h00; mem[16'hC002] = 8'h20;
        mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h56; mem[16'h0000] = 8'h78;
        reinit();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'hFFFC);
        chk("rst_ready", 32'(bus.instruction_ready), 32'd0);
        chk("rst_instruction", 32'(bus.instruction), 32'd0);
        chk("rst_operand", 32'(bus.operand), 32'd0);
        chk("rst_addr", 32'(bus.addr), 32'd0);
        chk("rst_pc_out", 32'(bus.pc_out), 32'd0);

        @(posedge clk); #2;
        reset = 1'b0; en = 1;
        @(posedge clk); #2;
        chk("vec_rd_rise", 32'(bus.mem_rd), 32'd1);
        chk("vec_addr0", 32'(bus.mem_addr), 32'hFFFC);
        @(posedge clk); #2;
        chk("vec_addr1", 32'(bus.mem_addr), 32'hFFFD);
        @(posedge clk); #2;
        chk("vec_addr2", 32'(bus.mem_addr), 32'h8000);
        chk("vec_pc", 32'(bus.pc_out), 32'h8000);

        ld_en = 0;
        wait_issue(1);
        chk("abs_instr", 32'(bus.instruction), 32'hAD);
        chk("abs_addr", 32'(bus.addr), 32'h1234);
        chk("abs_operand", 32'(bus.operand), 32'h34);
        chk("abs_pc", 32'(bus.pc_out), 32'h8003);
        chk("abs_latency", 32'(last_lat), 32'd5);
        wait_issue(2);
        chk("zp_addr", 32'(bus.addr), 32'h0044);
        ld_en = 1; ld_val = 16'h8010;
        wait_issue(3);
        chk("nop_instr", 32'(bus.instruction), 32'hEA);
        chk("nop_addr", 32'(bus.addr), 32'h8006);
        chk("nop_latency", 32'(last_lat), 32'd3);
        ld_val = 16'hC000;
        wait_issue(4);
        chk("imm_addr", 32'(bus.addr), 32'h8011);
        chk("imm_operand", 32'(bus.operand), 32'h7F);
        wmode = 2; ld_val = 16'hFFFE;
        @(posedge clk); #2;
        chk("redirect_addr", 32'(bus.mem_addr), 32'hC000);
        wait_issue(5);
        wmode = 0;
        chk("wait_addr", 32'(bus.addr), 32'h2000);
        chk("wait_latency", 32'(last_lat), 32'd14);
        wait_issue(6);
        chk("wrap_addr", 32'(bus.addr), 32'h7856);
        chk("wrap_pc", 32'(bus.pc_out), 32'h0001);

        // Re-run the wrapping instruction and hit reset while its high byte is pending.
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #2;
            if (bus.mem_rd && bus.mem_addr == 16'h0000) found = 1;
        end
        chk("reached_fetch_hi", 32'(found), 32'd1);
        reset = 1'b1; en = 0;
        #1;
        chk("midrst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("midrst_ready", 32'(bus.instruction_ready), 32'd0);
        chk("midrst_mem_addr", 32'(bus.mem_addr), 32'hFFFC);
        chk("midrst_pc", 32'(bus.pc_out), 32'd0);
        chk("midrst_instr", 32'(bus.instruction), 32'd0);
        @(posedge clk);
        @(posedge clk); #2;
        reinit();
        reset = 1'b0; en = 1;
        @(posedge clk); #2;
        chk("restart_rd", 32'(bus.mem_rd), 32'd1);
        chk("restart_addr", 32'(bus.mem_addr), 32'hFFFC);

        done_mode = 1; wmode = 1; rnd_ld = 1;
        base = n_issued;
        t = 0;
        while (n_issued < base + 80 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("random_issue_count", 32'(n_issued >= base + 80), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
